// File: rtl/uart_pkg.sv
// Shared definitions for the port UART transmitter: FSM state encoding,
// default timing/buffer parameters and the parity helper.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 139;  // 16 MHz / 115200 baud
  localparam int DEFAULT_FIFO_DEPTH   = 4;
  localparam int DATA_BITS            = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. Fall-through read (pop_data is the
// head entry), full is registered, and a pop never frees room for a same-cycle push.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               push_data,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push  = push & ~full_q;
    do_pop   = pop & (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == (AW+1)'(DEPTH));
  end

  // Storage carries no reset; pointers and count alone define the contents.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign pop_data = mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;

endmodule

// File: rtl/port_uart_tx.sv
// Buffered UART transmitter between a processor output-port byte and a pin.
// Default frame is 8N1; define UART_TX_PARITY_EN to insert an even-parity bit.
module port_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  localparam int         CW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic        fifo_pop;
  logic [7:0]  fifo_data;
  logic [CW:0] fifo_count;
  logic        fifo_full;
  logic        baud_last;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (wr_en),
    .pop       (fifo_pop),
    .push_data (wr_data),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_data);
`endif
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_d = parity_q;
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        // Returning to IDLE (rather than popping here) yields the one idle cycle between frames.
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Registered from current state so tx and busy share one cycle of lag.
    busy_d     = (state_q != ST_IDLE) || (fifo_count != '0);
    overflow_d = overflow_q | (wr_en & fifo_full);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Self-checking bench for port_uart_tx: table of single-frame vectors, a
// frame-decoding monitor with a scoreboard queue, and multi-cycle corner sequences.
module tb_port_uart_tx;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CLKS;

  typedef struct {
    logic [7:0]            data;
    logic [FRAME_BITS-1:0] frame;
  } vec_t;

  logic       CLK;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     frames_seen = 0;
  longint cyc = 0;
  longint last_start = -1;
  longint start_q[$];
  logic [FRAME_BITS-1:0] exp_q[$];

  port_uart_tx #(
    .CLKS_PER_BIT(CLKS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic wait_idle(output longint t_fall);
    bit done;
    done   = 1'b0;
    t_fall = -1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge CLK);
      if (busy === 1'b0) begin
        done   = 1'b1;
        t_fall = cyc;
      end
    end
    check("idle_timeout", done, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Frame monitor: samples every cycle of every bit on the falling edge.
  initial begin : monitor
    logic [FRAME_BITS-1:0] bits;
    logic [FRAME_BITS-1:0] exp;
    logic   stable;
    logic   aborted;
    longint t0;
    forever begin
      @(negedge CLK);
      if (reset === 1'b1 && tx === 1'b0) begin
        t0      = cyc;
        bits    = '0;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < FRAME_BITS; b++) begin
          for (int c = 0; c < CLKS; c++) begin
            if (b != 0 || c != 0) @(negedge CLK);
            if (reset !== 1'b1) aborted = 1'b1;
            if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          start_q.push_back(t0);
          last_start = t0;
          frames_seen++;
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check("frame_bits", bits, exp);
            $display("frame %0d start=%0d bits=%b expected=%b", frames_seen, t0, bits, exp);
          end
          check("frame_stable", stable, 1);
        end
      end
    end
  end

  initial begin : stim
    vec_t   vecs[6];
    logic [7:0] seq[6];
    longint c_w;
    longint t_fall;
    int     n0;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};
    vecs[1] = '{8'h01, {1'b1, 1'b1, 8'h01, 1'b0}};
    vecs[2] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
    vecs[3] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
    vecs[4] = '{8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}};
    vecs[5] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}};
`else
    vecs[0] = '{8'hA5, {1'b1, 8'hA5, 1'b0}};
    vecs[1] = '{8'h01, {1'b1, 8'h01, 1'b0}};
    vecs[2] = '{8'h00, {1'b1, 8'h00, 1'b0}};
    vecs[3] = '{8'hFF, {1'b1, 8'hFF, 1'b0}};
    vecs[4] = '{8'h3C, {1'b1, 8'h3C, 1'b0}};
    vecs[5] = '{8'h80, {1'b1, 8'h80, 1'b0}};
`endif
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
    seq[3] = 8'h44; seq[4] = 8'h55; seq[5] = 8'h66;

    wr_en   = 1'b0;
    wr_data = 8'h00;
    reset   = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_full", full, 0);
    check("reset_overflow", overflow, 0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    // Single frames: latency, busy window and frame contents.
    for (int v = 0; v < 6; v++) begin
      @(negedge CLK);
      wr_en   = 1'b1;
      wr_data = vecs[v].data;
      exp_q.push_back(vecs[v].frame);
      c_w = cyc;
      @(negedge CLK);
      wr_en = 1'b0;
      @(negedge CLK);
      check("busy_rise", busy, 1);
      wait_idle(t_fall);
      check("start_latency", last_start - c_w, 3);
      check("busy_fall", t_fall - last_start, FRAME_CYC);
      $display("vector %0d data=%02h start=%0d busy_fall=%0d", v, vecs[v].data, last_start, t_fall);
    end

    // Six back-to-back writes into a depth-4 FIFO: fifth fills it, sixth overflows.
    start_q.delete();
    n0 = frames_seen;
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = seq[i];
      if (i < 5) exp_q.push_back(mk_frame(seq[i]));
      @(negedge CLK);
      check("burst_full", full, (i >= 4) ? 1 : 0);
      check("burst_overflow", overflow, (i >= 5) ? 1 : 0);
      $display("burst write %0d data=%02h full=%0b overflow=%0b", i, seq[i], full, overflow);
    end
    wr_en = 1'b0;
    wait_idle(t_fall);
    check("burst_frames", frames_seen - n0, 5);
    check("burst_starts", start_q.size(), 5);
    for (int i = 1; i < 5 && i < start_q.size(); i++) begin
      check("burst_gap", start_q[i] - start_q[i-1], FRAME_CYC + 1);
    end

    // 0x00 then 0xFF back to back.
    start_q.delete();
    @(negedge CLK);
    wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(mk_frame(8'h00));
    @(negedge CLK);
    wr_data = 8'hFF; exp_q.push_back(mk_frame(8'hFF));
    @(negedge CLK);
    wr_en = 1'b0;
    wait_idle(t_fall);
    check("pair_starts", start_q.size(), 2);
    if (start_q.size() == 2) check("pair_gap", start_q[1] - start_q[0], FRAME_CYC + 1);

    // Reset during data bit 3 with two bytes still queued.
    n0 = frames_seen;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'hC3 + 8'(i);
      exp_q.push_back(mk_frame(8'hC3 + 8'(i)));
      @(negedge CLK);
    end
    wr_en = 1'b0;
    repeat (18) @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_full", full, 0);
    check("abort_overflow", overflow, 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    #2 reset = 1'b1;
    repeat (100) @(negedge CLK);
    check("post_abort_busy", busy, 0);
    check("post_abort_tx", tx, 1);
    check("post_abort_frames", frames_seen - n0, 0);
    $display("reset abort: frames after release=%0d", frames_seen - n0);

    // First write accepted on the very first edge after release.
    @(negedge CLK);
    #2 reset = 1'b0;
    repeat (2) @(negedge CLK);
    #2 reset = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    exp_q.push_back(mk_frame(8'h5A));
    c_w = cyc;
    @(negedge CLK);
    wr_en = 1'b0;
    wait_idle(t_fall);
    check("release_latency", last_start - c_w, 3);
    check("release_busy_fall", t_fall - last_start, FRAME_CYC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
